// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative MULT/MULTU/DIV/DIVU unit, one shift-add/subtract step per cycle
// through a single shared (Width+1)-bit adder, signs fixed up in a final cycle.
module mdu_sequencer #(
    parameter int Width    = 32,
    parameter int CntWidth = $clog2(Width)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [Width-1:0] hi_o,
    output logic [Width-1:0] lo_o
);
    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          op_q;
    logic                sign_q, sign_r, dz_q;
    logic [Width-1:0]    acc_q, mq_q, mb_q;
    logic [CntWidth-1:0] cnt_q;
    logic                accept, is_div;
    logic [Width-1:0]    a_abs, b_abs;
    logic [Width:0]      add_a, add_b;
    logic [Width+1:0]    add_r;
    logic [2*Width-1:0]  prod_neg;

    assign accept   = (state_q == IDLE || state_q == DONE) && start_i && !flush_i;
    assign a_abs    = (op_i[0] && a_i[Width-1]) ? -a_i : a_i;
    assign b_abs    = (op_i[0] && b_i[Width-1]) ? -b_i : b_i;
    assign is_div   = op_q[1];
    assign busy_o   = state_q == CALC || state_q == SIGN;
    assign done_o   = state_q == DONE;
    assign prod_neg = -{acc_q, mq_q};

    // Divide subtracts via ~divisor + 1; carry-out set means no borrow.
    assign add_a = is_div ? {acc_q, mq_q[Width-1]} : {1'b0, acc_q};
    assign add_b = is_div ? ~{1'b0, mb_q} : (mq_q[0] ? {1'b0, mb_q} : '0);
    assign add_r = {1'b0, add_a} + {1'b0, add_b} + {{(Width+1){1'b0}}, is_div};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = accept ? CALC : IDLE;
            CALC:       state_d = flush_i ? IDLE : (cnt_q == '0 ? SIGN : CALC);
            SIGN:       state_d = flush_i ? IDLE : DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q    <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            dz_q    <= 1'b0;
            acc_q   <= '0;
            mq_q    <= '0;
            mb_q    <= '0;
            cnt_q   <= '0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= op_i;
                mb_q   <= b_abs;
                mq_q   <= a_abs;
                acc_q  <= '0;
                cnt_q  <= CntWidth'(Width - 1);
                sign_q <= op_i[0] & (a_i[Width-1] ^ b_i[Width-1]);
                sign_r <= op_i[0] & a_i[Width-1];
                dz_q   <= op_i[1] && b_i == '0;
            end else if (state_q == CALC && !flush_i) begin
                cnt_q <= cnt_q - CntWidth'(1);
                if (is_div) begin
                    acc_q <= add_r[Width+1] ? add_r[Width-1:0] : add_a[Width-1:0];
                    mq_q  <= {mq_q[Width-2:0], add_r[Width+1]};
                end else begin
                    {acc_q, mq_q} <= {add_r[Width:0], mq_q[Width-1:1]};
                end
            end else if (state_q == SIGN && !flush_i) begin
                // Divide by zero leaves quotient all ones; remainder fixup restores raw a.
                if (is_div) begin
                    lo_o <= dz_q ? '1 : (sign_q ? -mq_q : mq_q);
                    hi_o <= sign_r ? -acc_q : acc_q;
                end else begin
                    {hi_o, lo_o} <= sign_q ? prod_neg : {acc_q, mq_q};
                end
            end
        end
    end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: scenario tasks against a 64-bit arithmetic reference model.
module tb_mdu_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;
    logic [31:0] last_hi = '0, last_lo = '0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    mdu_sequencer #(.Width(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .flush_i(flush), .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
    );

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy;
        int qi, ri;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        if (o == 2'd0) return {32'd0, x} * {32'd0, y};
        if (o == 2'd1) return sx * sy;
        if (y == 0) return {x, 32'hFFFFFFFF};
        if (o == 2'd2) return {x % y, x / y};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        qi = $signed(x) / $signed(y);
        ri = $signed(x) % $signed(y);
        return {32'(ri), 32'(qi)};
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n, output int bc);
        n = 0; bc = 0;
        while (!done && n < 100) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset hi: got %h want 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset lo: got %h want 0", lo); end
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [1:0]  dop[5] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd3};
        logic [31:0] da[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000};
        logic [31:0] db[5]  = '{32'hFFFFFFFF, 32'd5, 32'd2, 32'd0, 32'hFFFFFFFF};
        logic [31:0] eh[5]  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'd0};
        logic [31:0] el[5]  = '{32'h00000001, 32'hFFFFFFF1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
        int n, bc;
        for (int i = 0; i < 5; i++) begin
            issue(dop[i], da[i], db[i]);
            wait_done(n, bc);
            checks++; if (n !== 33) begin errors++; $display("FAIL directed%0d latency: got %0d want 33", i, n); end
            checks++; if (bc !== 33) begin errors++; $display("FAIL directed%0d busy cycles: got %0d want 33", i, bc); end
            checks++; if (hi !== eh[i]) begin errors++; $display("FAIL directed%0d hi: got %h want %h", i, hi, eh[i]); end
            checks++; if (lo !== el[i]) begin errors++; $display("FAIL directed%0d lo: got %h want %h", i, lo, el[i]); end
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL directed%0d done pulse width: got %b want 0", i, done); end
            last_hi = eh[i]; last_lo = el[i];
        end
    endtask

    task automatic test_random;
        logic [1:0]  o;
        logic [31:0] x, y;
        logic [63:0] e;
        int n, bc;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: y = 32'hFFFFFFFF;
                2: y = $urandom_range(1, 20);
                3: x = 32'h80000000;
                default: ;
            endcase
            e = model(o, x, y);
            issue(o, x, y);
            wait_done(n, bc);
            checks++; if (n !== 33) begin errors++; $display("FAIL random%0d latency: got %0d want 33", i, n); end
            checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL random%0d op=%0d a=%h b=%h: got %h_%h want %h", i, o, x, y, hi, lo, e); end
            last_hi = e[63:32]; last_lo = e[31:0];
        end
    endtask

    task automatic test_back_to_back;
        int n, bc;
        issue(2'd0, 32'd123, 32'd456);
        n = 0;
        while (!done && n < 100) begin
            if (n == 10) begin start = 1'b1; op = 2'd3; a = 32'hDEADBEEF; b = 32'd7; end
            else start = 1'b0;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        checks++; if (n !== 33) begin errors++; $display("FAIL b2b first latency: got %0d want 33", n); end
        checks++; if ({hi, lo} !== 64'd56088) begin errors++; $display("FAIL b2b first result: got %h_%h want 0_0000db18", hi, lo); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b done at reissue: got %b want 1", done); end
        op = 2'd2; a = 32'd17; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b busy after reissue: got busy=%b done=%b want 1/0", busy, done); end
        wait_done(n, bc);
        checks++; if (n !== 33) begin errors++; $display("FAIL b2b second latency: got %0d want 33", n); end
        checks++; if (hi !== 32'd2 || lo !== 32'd3) begin errors++; $display("FAIL b2b second result: got %h_%h want 2_3", hi, lo); end
        last_hi = 32'd2; last_lo = 32'd3;
    endtask

    task automatic test_flush;
        int n, bc;
        logic seen;
        issue(2'd1, 32'h12345678, 32'hFEDCBA98);
        repeat (15) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL flush idle: got busy=%b done=%b want 0/0", busy, done); end
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (done) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush done pulse: got 1 want 0"); end
        checks++; if (hi !== last_hi || lo !== last_lo) begin errors++; $display("FAIL flush hold: got %h_%h want %h_%h", hi, lo, last_hi, last_lo); end
        issue(2'd2, 32'd50, 32'd7);
        wait_done(n, bc);
        checks++; if (hi !== 32'd1 || lo !== 32'd7) begin errors++; $display("FAIL flush divu: got %h_%h want 1_7", hi, lo); end
        start = 1'b1; flush = 1'b1; op = 2'd0; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL flush+start in done: got busy=%b done=%b want 0/0", busy, done); end
        repeat (35) @(negedge clk);
        checks++; if (hi !== 32'd1 || lo !== 32'd7) begin errors++; $display("FAIL flush+start result kept: got %h_%h want 1_7", hi, lo); end
        last_hi = 32'd1; last_lo = 32'd7;
    endtask

    task automatic test_async_reset;
        int n, bc;
        issue(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL async reset ctl: got busy=%b done=%b want 0/0", busy, done); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL async reset data: got %h_%h want 0_0", hi, lo); end
        @(negedge clk);
        rst_n = 1'b1;
        issue(2'd0, 32'd6, 32'd7);
        wait_done(n, bc);
        checks++; if (n !== 33) begin errors++; $display("FAIL post-reset latency: got %0d want 33", n); end
        checks++; if (hi !== 32'd0 || lo !== 32'd42) begin errors++; $display("FAIL post-reset multu: got %h_%h want 0_2a", hi, lo); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Iterative multiply/divide unit for the MIPS pipeline. Executes MULT/MULTU/DIV/DIVU with a single shared (Width+1)-bit add/subtract path, one iteration per cycle.
- Sequenced by an internal FSM. The EX stage issues a start pulse, stalls on busy_o, and captures the HI/LO results on done_o.
- Replaces a combinational 64-bit multiplier/divider to stay off the critical path.

Parameters:
- Width, 32, operand width; hi_o and lo_o are each Width bits; iteration count = Width.
- CntWidth, $clog2(Width), iteration counter width.

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_ni  input  1  asynchronous active-low reset
- start_i  input  1  request new operation; sampled only in IDLE or DONE
- op_i  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start_i
- a_i  input  Width  multiplicand / dividend (rs); sampled with start_i
- b_i  input  Width  multiplier / divisor (rt); sampled with start_i
- flush_i  input  1  synchronous abort of the in-flight operation
- busy_o  output  1  high in CALC and SIGN states
- done_o  output  1  single-cycle pulse, high in DONE state
- hi_o  output  Width  HI result (product upper half / remainder)
- lo_o  output  Width  LO result (product lower half / quotient)

Behaviour:
- Reset (async, rst_ni=0): state=IDLE, busy_o=0, done_o=0, hi_o=0, lo_o=0, counter and internal accumulators=0. Applies immediately, including mid-operation.
- FSM states: IDLE -> CALC -> SIGN -> DONE -> IDLE.
  - start_i=1 in IDLE or DONE moves to CALC.
  - DONE with no start returns to IDLE.
- On accept (edge E0):
  - Latch op_i.
  - For signed ops, latch |a_i| and |b_i|, sign_q = a[W-1]^b[W-1] and sign_r = a[W-1]. Unsigned ops latch raw values with both signs 0.
  - Clear acc, load counter=Width-1.
- CALC: one iteration per edge E1..E_Width; moves to SIGN on the edge where counter==0.
  - Multiply: if multiplier lsb=1 then {c,acc} = acc + mcand (Width+1 bits), else {c,acc} = acc+0. Then {c,acc,mplier} shifts right by 1.
  - Divide (restoring): {rem,quot} shifts left by 1, then trial = rem - divisor over Width+1 bits. If no borrow, rem = trial and quot[0] = 1; else quot[0] = 0.
- SIGN (1 cycle, edge E_Width+1): apply sign fixup, write hi_o/lo_o, move to DONE.
  - MULT with sign_q: 2*Width-bit two's-complement negate of {hi,lo}.
  - DIV: negate quotient if sign_q; negate remainder if sign_r.
- Latency: done_o is high in the cycle after edge E_Width+1, i.e. exactly Width+1 edges after the accepting edge (33 for Width=32). It stays high for one cycle.
- hi_o/lo_o are registered. They change only in SIGN or on reset and hold between operations, including across flush.
- start_i in CALC/SIGN is ignored (no queueing); operand changes during busy have no effect.
- start_i in DONE: accepted. done_o is still 1 that cycle; busy_o rises next cycle. Back-to-back issue with no idle gap.
- flush_i=1 in CALC/SIGN: next state IDLE, no hi/lo write, done_o never pulses. flush_i has priority over start_i in the same cycle. flush_i in IDLE/DONE: no effect other than blocking start.
- Divide by zero (b_i==0, DIVU or DIV): no trap. lo_o = all ones, hi_o = original a_i (raw, sign fixup skipped), same latency.
- DIV 0x80000000 / -1: lo_o = 0x80000000, hi_o = 0 (wrap, no trap).
- Negating the most-negative value yields itself; no saturation anywhere.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done_o 33 edges after start; hi=0xFFFFFFFE, lo=0x00000001; busy_o high exactly 32+1 cycles.
- MULT a=-3 (0xFFFFFFFD), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Back-to-back: assert start in the DONE cycle with DIVU 17/5 -> second done_o 33 edges later with lo=3, hi=2. A start pulse at cycle 10 of CALC is ignored and the first result is unchanged.
- flush_i at CALC iteration 15 -> IDLE next cycle, no done_o, hi/lo keep the previous values. Flush+start together in DONE -> stays IDLE.
- rst_ni low mid-CALC, asynchronous to clock -> busy_o, done_o, hi_o, lo_o = 0 immediately. A new MULTU 6*7 after release -> lo=42, hi=0.
